gen_fifo_unpack: RTL and testbench

- Read-side companion to the team's generic push/pop FIFO.
- Drains DW-wide words through the FIFO pop interface and serialises each word into DW/OW narrow beats on a valid/ready output, LSB beat first.
- Sits between a wide producer FIFO (e.g. a trace or commit buffer) and a narrow consumer such as a debug or UART bridge.
- Zero-bubble: back-to-back words stream with no idle cycle when the consumer is always ready.

---
 rtl/gen_fifo_unpack_pkg.sv | 12 +
 rtl/gen_dffr.sv | 24 ++
 rtl/gen_rsffr.sv | 24 ++
 rtl/gen_fifo_unpack.sv | 89 ++++++++
 tb/tb_gen_fifo_unpack.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gen_fifo_unpack_pkg.sv
// Shared types for the FIFO word unpacker: the per-cycle update action.
package gen_fifo_unpack_pkg;

  typedef enum logic [2:0] {
    ACT_IDLE,
    ACT_FLUSH,
    ACT_POP,
    ACT_DRAIN,
    ACT_STEP
  } act_e;

endpackage

// File: rtl/gen_dffr.sv
// Enabled D flip-flop bank with asynchronous active-low clear to zero.
module gen_dffr #(
  parameter int unsigned W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gen_rsffr.sv
// Set/clear flag flip-flop; clear wins over set, async active-low reset to zero.
module gen_rsffr (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_q
);

  logic r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= 1'b0;
    end else if (i_clr) begin
      r_q <= 1'b0;
    end else if (i_set) begin
      r_q <= 1'b1;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/gen_fifo_unpack.sv
// Pops DW-wide FIFO words and serialises each into DW/OW narrow beats, LSB beat first.
module gen_fifo_unpack
  import gen_fifo_unpack_pkg::*;
#(
  parameter int unsigned DW = 64,
  parameter int unsigned OW = 16,
  parameter int unsigned CW = 2
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] data_pop,
  output logic          fifo_pop,
  input  logic          flush,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_data,
  output logic          out_last,
  output logic [CW-1:0] beat_idx
);

  localparam int unsigned R = DW / OW;
  localparam logic [CW-1:0] LAST_BEAT = CW'(R - 1);

  generate
    if (((DW % OW) != 0) || ((2 ** CW) < R)) begin : g_param_err
      $error("gen_fifo_unpack: DW must be a multiple of OW and 2**CW >= DW/OW");
    end
  endgenerate

  logic [DW-1:0] w_hold;
  logic          w_hold_valid;
  logic [CW-1:0] w_beat;
  logic [CW-1:0] w_beat_d;
  logic          w_accept;
  logic          w_drain;
  act_e          w_act;

  assign w_accept = w_hold_valid & out_ready;
  assign w_drain  = w_accept & out_last;
  // No pop while in reset: the hold is empty then, so the refill term would fire.
  assign fifo_pop = RSTn & ~fifo_empty & ~flush & (~w_hold_valid | w_drain);

  // Priority-ordered update action for the hold/beat pair.
  always_comb begin
    w_act = ACT_IDLE;
    if (flush) begin
      w_act = ACT_FLUSH;
    end else if (fifo_pop) begin
      w_act = ACT_POP;
    end else if (w_drain) begin
      w_act = ACT_DRAIN;
    end else if (w_accept) begin
      w_act = ACT_STEP;
    end
  end

  assign w_beat_d = (w_act == ACT_STEP) ? (w_beat + CW'(1)) : '0;

  gen_dffr #(.W(DW)) u_hold (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_en    (w_act == ACT_POP),
    .i_d     (data_pop),
    .o_q     (w_hold)
  );

  gen_dffr #(.W(CW)) u_beat (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_en    (w_act != ACT_IDLE),
    .i_d     (w_beat_d),
    .o_q     (w_beat)
  );

  gen_rsffr u_hold_valid (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_set   (w_act == ACT_POP),
    .i_clr   ((w_act == ACT_FLUSH) || (w_act == ACT_DRAIN)),
    .o_q     (w_hold_valid)
  );

  assign out_valid = w_hold_valid;
  assign out_data  = OW'(w_hold >> (OW * int'(w_beat)));
  assign out_last  = w_hold_valid & (w_beat == LAST_BEAT);
  assign beat_idx  = w_beat;

endmodule

// File: tb/tb_gen_fifo_unpack.sv
// Scoreboard bench for gen_fifo_unpack: 64/16 instance plus a 32/32 (one beat per word) instance.
module tb_gen_fifo_unpack;

  typedef struct {
    logic [63:0] data;
    logic        last;
    int          idx;
    int          cyc;
  } beat_t;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        fifo_empty, fifo_pop, flush, out_valid, out_ready, out_last;
  logic [63:0] data_pop;
  logic [15:0] out_data;
  logic [1:0]  beat_idx;
  logic        fifo_empty1, fifo_pop1, flush1, out_valid1, out_ready1, out_last1;
  logic [31:0] data_pop1;
  logic [31:0] out_data1;
  logic [0:0]  beat_idx1;

  beat_t       exp_q[$];
  beat_t       exp1_q[$];
  logic [63:0] fifo_q[$];
  logic [31:0] fifo1_q[$];
  int n_vec = 0;
  int n_err = 0;
  int mcyc  = 0;
  int pops  = 0;
  int pops1 = 0;

  always #5 CLK = ~CLK;

  gen_fifo_unpack #(.DW(64), .OW(16), .CW(2)) dut (
    .CLK(CLK), .RSTn(RSTn), .fifo_empty(fifo_empty), .data_pop(data_pop),
    .fifo_pop(fifo_pop), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .beat_idx(beat_idx)
  );

  gen_fifo_unpack #(.DW(32), .OW(32), .CW(1)) dut1 (
    .CLK(CLK), .RSTn(RSTn), .fifo_empty(fifo_empty1), .data_pop(data_pop1),
    .fifo_pop(fifo_pop1), .flush(flush1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_data(out_data1), .out_last(out_last1), .beat_idx(beat_idx1)
  );

  task automatic sync_fifo();
    fifo_empty  = (fifo_q.size() == 0);
    data_pop    = fifo_empty ? 64'h0 : fifo_q[0];
    fifo_empty1 = (fifo1_q.size() == 0);
    data_pop1   = fifo_empty1 ? 32'h0 : fifo1_q[0];
  endtask

  // One clock: latch pop strobes mid-cycle, advance the FIFO model after the edge.
  task automatic step();
    logic p, p1;
    @(negedge CLK);
    p  = fifo_pop;
    p1 = fifo_pop1;
    @(posedge CLK);
    #1;
    if (p && fifo_q.size() > 0) begin
      void'(fifo_q.pop_front());
      pops++;
    end
    if (p1 && fifo1_q.size() > 0) begin
      void'(fifo1_q.pop_front());
      pops1++;
    end
    sync_fifo();
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, mcyc);
    end
  endtask

  task automatic push_beat(input logic [63:0] d, input logic last, input int idx, input int cyc);
    beat_t b;
    b.data = d;
    b.last = last;
    b.idx  = idx;
    b.cyc  = cyc;
    exp_q.push_back(b);
  endtask

  task automatic push_word(input logic [63:0] w, input int first_cyc);
    for (int i = 0; i < 4; i++) begin
      push_beat(64'(w[i*16 +: 16]), (i == 3), i, first_cyc + i);
    end
  endtask

  // Monitor: every accepted beat is popped from the scoreboard and compared.
  initial begin
    beat_t e;
    forever begin
      @(negedge CLK);
      if (out_valid && out_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL beat: unexpected beat data %0h idx %0d at cycle %0d", out_data, beat_idx, mcyc);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.data[15:0] || out_last !== e.last || beat_idx !== 2'(e.idx) || mcyc != e.cyc) begin
            n_err++;
            $display("FAIL beat: got data %0h last %0b idx %0d cycle %0d, expected data %0h last %0b idx %0d cycle %0d",
                     out_data, out_last, beat_idx, mcyc, e.data[15:0], e.last, e.idx, e.cyc);
          end
        end
      end
      if (out_valid1 && out_ready1) begin
        n_vec++;
        if (exp1_q.size() == 0) begin
          n_err++;
          $display("FAIL beat1: unexpected beat data %0h at cycle %0d", out_data1, mcyc);
        end else begin
          e = exp1_q.pop_front();
          if (out_data1 !== e.data[31:0] || out_last1 !== e.last || beat_idx1 !== 1'(e.idx) || mcyc != e.cyc) begin
            n_err++;
            $display("FAIL beat1: got data %0h last %0b idx %0d cycle %0d, expected data %0h last %0b idx %0d cycle %0d",
                     out_data1, out_last1, beat_idx1, mcyc, e.data[31:0], e.last, e.idx, e.cyc);
          end
        end
      end
      @(posedge CLK);
      mcyc++;
    end
  end

  initial begin
    int t0;
    int p0;
    beat_t b;
    RSTn = 1'b0; flush = 1'b0; out_ready = 1'b0; flush1 = 1'b0; out_ready1 = 1'b0;
    sync_fifo();
    #2;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_data",  64'(out_data),  64'(0));
    chk("rst_last",  64'(out_last),  64'(0));
    chk("rst_idx",   64'(beat_idx),  64'(0));
    chk("rst_pop",   64'(fifo_pop),  64'(0));
    chk("rst_valid1", 64'(out_valid1), 64'(0));
    repeat (2) @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // Single word, consumer always ready.
    out_ready = 1'b1;
    fifo_q.push_back(64'h4444_3333_2222_1111);
    sync_fifo();
    t0 = mcyc; p0 = pops;
    push_word(64'h4444_3333_2222_1111, t0 + 1);
    for (int c = 0; c <= 5; c++) begin
      #1;
      if (c == 0) chk("s1_pop", 64'(fifo_pop), 64'(1));
      if (c == 5) chk("s1_idle", 64'(out_valid), 64'(0));
      chk("s1_last", 64'(out_last), 64'(c == 4));
      step();
    end
    chk("s1_pops", 64'(pops - p0), 64'(1));

    // Two words back to back; refill in the drain cycle.
    fifo_q.push_back(64'h8888_7777_6666_5555);
    fifo_q.push_back(64'hDDDD_CCCC_BBBB_AAAA);
    sync_fifo();
    t0 = mcyc; p0 = pops;
    push_word(64'h8888_7777_6666_5555, t0 + 1);
    push_word(64'hDDDD_CCCC_BBBB_AAAA, t0 + 5);
    for (int c = 0; c <= 9; c++) begin
      #1;
      if (c == 4) chk("s2_refill", 64'(fifo_pop), 64'(1));
      if (c >= 1 && c <= 8) chk("s2_valid", 64'(out_valid), 64'(1));
      if (c == 9) chk("s2_idle", 64'(out_valid), 64'(0));
      step();
    end
    chk("s2_pops", 64'(pops - p0), 64'(2));

    // Backpressure in cycles 2-4 with a second word waiting.
    fifo_q.push_back(64'h4444_3333_2222_1111);
    fifo_q.push_back(64'h9999_AAAA_BBBB_CCCC);
    sync_fifo();
    t0 = mcyc; p0 = pops;
    push_beat(64'h1111, 1'b0, 0, t0 + 1);
    push_beat(64'h2222, 1'b0, 1, t0 + 5);
    push_beat(64'h3333, 1'b0, 2, t0 + 6);
    push_beat(64'h4444, 1'b1, 3, t0 + 7);
    push_word(64'h9999_AAAA_BBBB_CCCC, t0 + 8);
    for (int c = 0; c <= 12; c++) begin
      out_ready = !(c >= 2 && c <= 4);
      #1;
      if (c >= 2 && c <= 4) begin
        chk("s3_hold_data", 64'(out_data), 64'h2222);
        chk("s3_hold_idx",  64'(beat_idx), 64'(1));
      end
      if (c >= 1 && c <= 6) chk("s3_nopop", 64'(fifo_pop), 64'(0));
      if (c == 7) chk("s3_refill", 64'(fifo_pop), 64'(1));
      if (c == 12) chk("s3_idle", 64'(out_valid), 64'(0));
      step();
    end
    out_ready = 1'b1;
    chk("s3_pops", 64'(pops - p0), 64'(2));

    // Flush at beat 2 while the next word arrives.
    fifo_q.push_back(64'h0404_0303_0202_0101);
    sync_fifo();
    t0 = mcyc;
    push_beat(64'h0101, 1'b0, 0, t0 + 1);
    push_beat(64'h0202, 1'b0, 1, t0 + 2);
    push_beat(64'h0303, 1'b0, 2, t0 + 3);
    push_word(64'h0B0B_0A0A_0909_0808, t0 + 5);
    for (int c = 0; c <= 9; c++) begin
      flush = (c == 3);
      if (c == 3) begin
        fifo_q.push_back(64'h0B0B_0A0A_0909_0808);
        sync_fifo();
      end
      #1;
      if (c == 3) begin
        chk("s4_flush_idx", 64'(beat_idx), 64'(2));
        chk("s4_flush_pop", 64'(fifo_pop), 64'(0));
      end
      if (c == 4) begin
        chk("s4_after_valid", 64'(out_valid), 64'(0));
        chk("s4_after_idx",   64'(beat_idx),  64'(0));
        chk("s4_after_pop",   64'(fifo_pop),  64'(1));
      end
      if (c == 9) chk("s4_idle", 64'(out_valid), 64'(0));
      step();
    end
    flush = 1'b0;

    // Flush with an empty hold as the FIFO turns non-empty: pop is deferred.
    fifo_q.push_back(64'h1234_5678_9ABC_DEF0);
    sync_fifo();
    flush = 1'b1;
    t0 = mcyc;
    push_word(64'h1234_5678_9ABC_DEF0, t0 + 2);
    #1;
    chk("s4b_pop_blocked", 64'(fifo_pop), 64'(0));
    step();
    flush = 1'b0;
    #1;
    chk("s4b_pop_next", 64'(fifo_pop), 64'(1));
    chk("s4b_valid", 64'(out_valid), 64'(0));
    for (int c = 1; c <= 5; c++) step();
    #1;
    chk("s4b_idle", 64'(out_valid), 64'(0));

    // Async reset mid-word, with another word already waiting.
    fifo_q.push_back(64'h5555_6666_7777_8888);
    sync_fifo();
    t0 = mcyc;
    push_word(64'h5555_6666_7777_8888, t0 + 1);
    step();
    step();
    fifo_q.push_back(64'h0F0F_0E0E_0D0D_0C0C);
    sync_fifo();
    #1;
    chk("s5_pre_idx", 64'(beat_idx), 64'(1));
    #1;
    RSTn = 1'b0;
    exp_q.delete();
    #1;
    chk("s5_rst_valid", 64'(out_valid), 64'(0));
    chk("s5_rst_data",  64'(out_data),  64'(0));
    chk("s5_rst_idx",   64'(beat_idx),  64'(0));
    chk("s5_rst_pop",   64'(fifo_pop),  64'(0));
    step();
    #2;
    RSTn = 1'b1;
    #1;
    chk("s5_first_pop", 64'(fifo_pop), 64'(1));
    push_word(64'h0F0F_0E0E_0D0D_0C0C, t0 + 4);
    for (int c = 3; c <= 7; c++) step();
    #1;
    chk("s5_idle", 64'(out_valid), 64'(0));
    chk("s5_fifo_empty", 64'(fifo_q.size()), 64'(0));

    // One beat per word: three words, one pop per cycle.
    out_ready1 = 1'b1;
    fifo1_q.push_back(32'hA1A1_0001);
    fifo1_q.push_back(32'hA1A1_0002);
    fifo1_q.push_back(32'hA1A1_0003);
    sync_fifo();
    t0 = mcyc; p0 = pops1;
    for (int i = 0; i < 3; i++) begin
      b.data = 64'(32'hA1A1_0001 + 32'(i));
      b.last = 1'b1;
      b.idx  = 0;
      b.cyc  = t0 + 1 + i;
      exp1_q.push_back(b);
    end
    for (int c = 0; c <= 4; c++) begin
      #1;
      if (c <= 3) chk("s6_pop", 64'(fifo_pop1), 64'(c <= 2));
      if (c >= 1 && c <= 3) chk("s6_last", 64'(out_last1), 64'(1));
      if (c == 4) chk("s6_idle", 64'(out_valid1), 64'(0));
      step();
    end
    chk("s6_pops", 64'(pops1 - p0), 64'(3));

    chk("sb_empty",  64'(exp_q.size()),  64'(0));
    chk("sb1_empty", 64'(exp1_q.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
